nibbler_control: RTL and testbench
==================================

Name: nibbler_control

Overview:
- Fetch/decode/execute controller for the 4-bit Nibbler datapath; drives the ALU operand/select inputs and consumes its result and flags.
- Owns PC, instruction register, accumulator and the C/Z flag register.
- Interfaces to a combinational program ROM, a data RAM and a 4-bit I/O port.
- Sits between the program memory and the ALU, closing the loop the ALU leaves open.

Parameters:
- PC_W, 12, program/data address width
- RESET_PC, 0, PC value loaded on reset

Ports:
- clk  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- pc  out  PC_W  program ROM address
- program_byte  in  8  ROM data, valid combinationally for current pc
- alu_s  out  3  ALU select: 0 pass A, 1 A-B compare, 2 pass B, 3 A+B, 4 NAND
- alu_a  out  4  ALU operand A (always accumulator)
- alu_b  out  4  ALU operand B
- alu_y  in  4  ALU result
- alu_c  in  1  ALU carry/borrow
- alu_zeta  in  1  ALU zero flag
- data_addr  out  PC_W  data RAM address
- data_in  in  4  RAM read data, combinational
- data_out  out  4  RAM write data (accumulator)
- data_we  out  1  RAM write strobe, one cycle
- in_port  in  4  input port
- out_port  out  4  registered output port
- out_valid  out  1  one-cycle pulse when out_port updated
- flag_c  out  1  registered carry flag
- flag_z  out  1  registered zero flag

Behaviour:
- Reset (asynchronous, reset=0):
  - pc=RESET_PC; accum=0; ir=0; addr_lo=0
  - flag_c=0, flag_z=0; out_port=0; out_valid=0; data_we=0
  - state=FETCH
  - alu_s=0, alu_b=0
- Reset mid-instruction aborts it; no partial write or pulse survives.
- States: FETCH -> (FETCH2 if two-byte) -> EXEC -> FETCH.
- FETCH:
  - ir<=program_byte; pc<=pc+1.
  - Next state FETCH2 for opcodes 0-4, 11, 12; else EXEC.
- FETCH2: addr_lo<=program_byte; pc<=pc+1; next EXEC.
- Target/data address = {ir[3:0], addr_lo}; imm = ir[3:0].
- PC increments modulo 2^PC_W (0xFFF+1 = 0x000); a two-byte instruction may straddle the wrap.
- EXEC, by opcode ir[7:4]:
  - 0 JC: pc<=target if flag_c=1.
  - 1 JNC: pc<=target if flag_c=0.
  - 2 JZ: pc<=target if flag_z=1.
  - 3 JNZ: pc<=target if flag_z=0.
  - 4 JMP: pc<=target unconditionally.
  - 5 CMPI: alu_s=1, alu_b=imm; flags<=alu_c/alu_zeta; accum unchanged.
  - 6 ADDI: alu_s=3, alu_b=imm; accum<=alu_y; flags updated.
  - 7 LIT: alu_s=2, alu_b=imm; accum<=alu_y; flags unchanged.
  - 8 NANDI: alu_s=4, alu_b=imm; accum<=alu_y; flags updated.
  - 9 IN: alu_s=2, alu_b=in_port; accum<=alu_y; flags unchanged.
  - 10 OUT: out_port<=accum; out_valid=1 for exactly this cycle's following edge window (one clk).
  - 11 LD: data_addr=target; alu_s=2, alu_b=data_in; accum<=alu_y; flags unchanged.
  - 12 ST: data_addr=target, data_out=accum, data_we=1 for this one cycle.
  - 13-15 NOP.
- Outside EXEC: alu_s=0, alu_b=0, data_we=0.
- alu_a=accum at all times.
- Flags change only on CMPI/ADDI/NANDI at the EXEC edge. A conditional jump in the next instruction sees the updated flags.
- Cycle counts: single-byte instruction 2 cycles; two-byte instruction 3 cycles; taken and untaken branches cost the same.
- All arithmetic is 4-bit; ADDI overflow is reported via flag_c and accum keeps the low nibble.

Test Plan:
- Reset release with ROM all 0xF0 (NOP) -> pc=0,1,2,... one increment every 2 cycles; outputs hold reset values; asserting reset mid-EXEC returns pc to 0 asynchronously.
- LIT 9; ADDI 8 -> accum=1, flag_c=1, flag_z=0; ADDI 15 -> accum=0, flag_c=1, flag_z=1.
- LIT 3; CMPI 5 -> flag_c=1, flag_z=0, accum stays 3; CMPI 3 -> flag_c=0, flag_z=1.
- CMPI equal then JZ 0x2A5 -> pc=0x2A5 after 3 cycles; JNZ same flags -> pc falls through to next byte.
- ST to 0x123 with accum=0xA -> data_we high exactly 1 cycle, data_addr=0x123, data_out=0xA; then LD 0x123 with data_in=0xA -> accum=0xA.
- IN with in_port=6, then OUT -> out_port=6, out_valid one-cycle pulse; two-byte JMP at pc=0xFFF wraps fetch correctly.

Source files
------------

// File: rtl/nibbler_control.sv
// Fetch/decode/execute controller for the 4-bit Nibbler datapath.
// Owns PC, IR, accumulator and C/Z flags; the ALU itself is external.
module nibbler_control #(
    parameter int              PC_W     = 12,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic [PC_W-1:0] pc,
    input  logic [7:0]      program_byte,
    output logic [2:0]      alu_s,
    output logic [3:0]      alu_a,
    output logic [3:0]      alu_b,
    input  logic [3:0]      alu_y,
    input  logic            alu_c,
    input  logic            alu_zeta,
    output logic [PC_W-1:0] data_addr,
    input  logic [3:0]      data_in,
    output logic [3:0]      data_out,
    output logic            data_we,
    input  logic [3:0]      in_port,
    output logic [3:0]      out_port,
    output logic            out_valid,
    output logic            flag_c,
    output logic            flag_z
);
    typedef enum logic [1:0] {
        S_FETCH  = 2'd0,
        S_FETCH2 = 2'd1,
        S_EXEC   = 2'd2
    } state_t;

    localparam logic [3:0] OP_JC    = 4'd0;
    localparam logic [3:0] OP_JNC   = 4'd1;
    localparam logic [3:0] OP_JZ    = 4'd2;
    localparam logic [3:0] OP_JNZ   = 4'd3;
    localparam logic [3:0] OP_JMP   = 4'd4;
    localparam logic [3:0] OP_CMPI  = 4'd5;
    localparam logic [3:0] OP_ADDI  = 4'd6;
    localparam logic [3:0] OP_LIT   = 4'd7;
    localparam logic [3:0] OP_NANDI = 4'd8;
    localparam logic [3:0] OP_IN    = 4'd9;
    localparam logic [3:0] OP_OUT   = 4'd10;
    localparam logic [3:0] OP_LD    = 4'd11;
    localparam logic [3:0] OP_ST    = 4'd12;

    localparam logic [2:0] ALU_CMP  = 3'd1;
    localparam logic [2:0] ALU_B    = 3'd2;
    localparam logic [2:0] ALU_ADD  = 3'd3;
    localparam logic [2:0] ALU_NAND = 3'd4;

    state_t          r_state;
    state_t          w_next;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_target;
    logic [PC_W-1:0] w_pc_inc;
    logic [7:0]      r_ir;
    logic [7:0]      r_addr_lo;
    logic [3:0]      r_accum;
    logic [3:0]      r_out_port;
    logic [3:0]      w_op;
    logic [3:0]      w_imm;
    logic [3:0]      w_fetch_op;
    logic            r_flag_c;
    logic            r_flag_z;
    logic            r_out_valid;
    logic            w_two_byte;
    logic            w_take;

    assign w_op       = r_ir[7:4];
    assign w_imm      = r_ir[3:0];
    assign w_target   = PC_W'({w_imm, r_addr_lo});
    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_fetch_op = program_byte[7:4];
    assign w_two_byte = (w_fetch_op <= OP_JMP) ||
                        (w_fetch_op == OP_LD)  ||
                        (w_fetch_op == OP_ST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        unique case (r_state)
            S_FETCH:  w_next = w_two_byte ? S_FETCH2 : S_EXEC;
            S_FETCH2: w_next = S_EXEC;
            S_EXEC:   w_next = S_FETCH;
            default:  w_next = S_FETCH;
        endcase
    end

    always_comb begin
        alu_s   = '0;
        alu_b   = '0;
        data_we = 1'b0;
        if (r_state == S_EXEC) begin
            case (w_op)
                OP_CMPI:  begin alu_s = ALU_CMP;  alu_b = w_imm;   end
                OP_ADDI:  begin alu_s = ALU_ADD;  alu_b = w_imm;   end
                OP_LIT:   begin alu_s = ALU_B;    alu_b = w_imm;   end
                OP_NANDI: begin alu_s = ALU_NAND; alu_b = w_imm;   end
                OP_IN:    begin alu_s = ALU_B;    alu_b = in_port; end
                OP_LD:    begin alu_s = ALU_B;    alu_b = data_in; end
                OP_ST:    data_we = 1'b1;
                default:  ;
            endcase
        end
    end

    always_comb begin
        w_take = 1'b0;
        case (w_op)
            OP_JC:   w_take = r_flag_c;
            OP_JNC:  w_take = !r_flag_c;
            OP_JZ:   w_take = r_flag_z;
            OP_JNZ:  w_take = !r_flag_z;
            OP_JMP:  w_take = 1'b1;
            default: w_take = 1'b0;
        endcase
    end

    // Output strobe is a register so it lines up with the new out_port value.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc        <= RESET_PC;
            r_ir        <= '0;
            r_addr_lo   <= '0;
            r_accum     <= '0;
            r_flag_c    <= 1'b0;
            r_flag_z    <= 1'b0;
            r_out_port  <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    r_ir <= program_byte;
                    r_pc <= w_pc_inc;
                end
                S_FETCH2: begin
                    r_addr_lo <= program_byte;
                    r_pc      <= w_pc_inc;
                end
                S_EXEC: begin
                    if (w_take) r_pc <= w_target;
                    case (w_op)
                        OP_CMPI: begin
                            r_flag_c <= alu_c;
                            r_flag_z <= alu_zeta;
                        end
                        OP_ADDI, OP_NANDI: begin
                            r_accum  <= alu_y;
                            r_flag_c <= alu_c;
                            r_flag_z <= alu_zeta;
                        end
                        OP_LIT, OP_IN, OP_LD: r_accum <= alu_y;
                        OP_OUT: begin
                            r_out_port  <= r_accum;
                            r_out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign pc        = r_pc;
    assign alu_a     = r_accum;
    assign data_addr = w_target;
    assign data_out  = r_accum;
    assign out_port  = r_out_port;
    assign out_valid = r_out_valid;
    assign flag_c    = r_flag_c;
    assign flag_z    = r_flag_z;
endmodule

// File: tb/tb_nibbler_control.sv
// Scoreboard bench for nibbler_control: an instruction-level model
// predicts per-instruction state, RAM writes and output pulses.
module tb_nibbler_control;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] pc;
    logic [7:0]  program_byte;
    logic [2:0]  alu_s;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic [3:0]  alu_y;
    logic        alu_c;
    logic        alu_zeta;
    logic [11:0] data_addr;
    logic [3:0]  data_in;
    logic [3:0]  data_out;
    logic        data_we;
    logic [3:0]  in_port = 4'h0;
    logic [3:0]  out_port;
    logic        out_valid;
    logic        flag_c;
    logic        flag_z;

    always #5 clk = ~clk;

    nibbler_control #(.PC_W(12), .RESET_PC(12'h000)) dut (
        .clk(clk), .reset(reset), .pc(pc), .program_byte(program_byte),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y),
        .alu_c(alu_c), .alu_zeta(alu_zeta), .data_addr(data_addr),
        .data_in(data_in), .data_out(data_out), .data_we(data_we),
        .in_port(in_port), .out_port(out_port), .out_valid(out_valid),
        .flag_c(flag_c), .flag_z(flag_z)
    );

    logic [7:0] rom   [4096];
    logic [3:0] ram   [4096];
    logic [3:0] m_ram [4096];

    assign program_byte = rom[pc];
    assign data_in      = ram[data_addr];

    always @(posedge clk) if (data_we) ram[data_addr] <= data_out;

    // ALU: compare reports borrow in C, zero flag from result
    logic [4:0] t;
    always_comb begin
        t = '0;
        case (alu_s)
            3'd0:    t = {1'b0, alu_a};
            3'd1:    t = {1'b0, alu_a} - {1'b0, alu_b};
            3'd2:    t = {1'b0, alu_b};
            3'd3:    t = {1'b0, alu_a} + {1'b0, alu_b};
            3'd4:    t = {1'b0, ~(alu_a & alu_b)};
            default: t = '0;
        endcase
        alu_y    = t[3:0];
        alu_c    = t[4];
        alu_zeta = (t[3:0] == 4'h0);
    end

    typedef struct {
        int         cyc;
        logic [11:0] pc;
        logic [3:0] acc;
        logic       fc;
        logic       fz;
        logic [3:0] outp;
    } st_t;

    typedef struct {
        int          cyc;
        logic        kind;
        logic [11:0] addr;
        logic [3:0]  d;
    } ev_t;

    st_t stq[$];
    ev_t evq[$];
    int  errs = 0;
    int  checks = 0;
    int  cyc = 0;
    int  lim = 0;
    bit  run = 1'b0;

    task automatic chk(input string nm, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, a, e);
        end
    endtask

    // Architectural model: one loop iteration per instruction.
    task automatic model(input int n, output int total);
        logic [11:0] p, p1, np, tgt;
        logic [7:0]  b0, b1;
        logic [3:0]  acc, op, imm, outp;
        logic [4:0]  s;
        logic        fc, fz;
        bit          two;
        int          c, len;
        p = 12'h000; acc = 4'h0; fc = 1'b0; fz = 1'b0;
        outp = 4'h0; c = 0;
        for (int i = 0; i < n; i++) begin
            stq.push_back('{cyc: c, pc: p, acc: acc, fc: fc, fz: fz,
                            outp: outp});
            p1  = p + 12'd1;
            b0  = rom[p];
            b1  = rom[p1];
            op  = b0[7:4];
            imm = b0[3:0];
            two = (op <= 4'd4) || (op == 4'd11) || (op == 4'd12);
            len = two ? 3 : 2;
            np  = two ? p + 12'd2 : p1;
            tgt = {imm, b1};
            case (op)
                4'd0: if (fc)  np = tgt;
                4'd1: if (!fc) np = tgt;
                4'd2: if (fz)  np = tgt;
                4'd3: if (!fz) np = tgt;
                4'd4: np = tgt;
                4'd5: begin fc = acc < imm; fz = acc == imm; end
                4'd6: begin
                    s = {1'b0, acc} + {1'b0, imm};
                    acc = s[3:0]; fc = s[4]; fz = (s[3:0] == 4'h0);
                end
                4'd7: acc = imm;
                4'd8: begin
                    acc = ~(acc & imm); fc = 1'b0; fz = (acc == 4'h0);
                end
                4'd9: acc = in_port;
                4'd10: begin
                    outp = acc;
                    evq.push_back('{cyc: c + len, kind: 1'b1,
                                    addr: 12'h000, d: acc});
                end
                4'd11: acc = m_ram[tgt];
                4'd12: begin
                    m_ram[tgt] = acc;
                    evq.push_back('{cyc: c + len - 1, kind: 1'b0,
                                    addr: tgt, d: acc});
                end
                default: ;
            endcase
            p = np;
            c += len;
        end
        total = c;
    endtask

    always @(negedge clk) begin
        st_t         e;
        ev_t         v;
        logic [63:0] xv;
        if (!run) cyc = 0;
        else if (cyc < lim) begin
            if (stq.size() > 0 && stq[0].cyc == cyc) begin
                e = stq.pop_front();
                chk("state", 64'({pc, alu_a, flag_c, flag_z, out_port}),
                    64'({e.pc, e.acc, e.fc, e.fz, e.outp}));
            end
            if (data_we) begin
                xv = '1;
                if (evq.size() > 0) begin
                    v  = evq.pop_front();
                    xv = 64'({v.cyc[15:0], v.kind, v.addr, v.d});
                end
                chk("store", 64'({cyc[15:0], 1'b0, data_addr, data_out}), xv);
            end
            if (out_valid) begin
                xv = '1;
                if (evq.size() > 0) begin
                    v  = evq.pop_front();
                    xv = 64'({v.cyc[15:0], v.kind, v.addr, v.d});
                end
                chk("out", 64'({cyc[15:0], 1'b1, 12'h000, out_port}), xv);
            end
            cyc++;
        end
    end

    task automatic run_prog(input int n);
        int total;
        run   = 1'b0;
        reset = 1'b0;
        stq.delete();
        evq.delete();
        for (int i = 0; i < 4096; i++) m_ram[i] = ram[i];
        model(n, total);
        lim = total;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        run = 1'b1;
        repeat (lim) @(posedge clk);
        #1 run = 1'b0;
        while (evq.size() > 0 && evq[$].cyc >= lim) void'(evq.pop_back());
        chk("drain", 64'({stq.size(), evq.size()}), 64'h0);
    endtask

    task automatic fill_nop();
        for (int i = 0; i < 4096; i++) rom[i] = 8'hF0;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 4'h0;
        fill_nop();
        #1;
        chk("reset", 64'({pc, alu_a, alu_s, alu_b, flag_c, flag_z,
                          out_port, out_valid, data_we}), 64'h0);

        run_prog(20);

        rom[12'h000] = 8'h79; rom[12'h001] = 8'h68;
        rom[12'h002] = 8'h6F; rom[12'h003] = 8'h73;
        rom[12'h004] = 8'h55; rom[12'h005] = 8'h53;
        rom[12'h006] = 8'h22; rom[12'h007] = 8'hA5;
        rom[12'h2A5] = 8'h32; rom[12'h2A6] = 8'hA5;
        rom[12'h2A7] = 8'h7A; rom[12'h2A8] = 8'hC1;
        rom[12'h2A9] = 8'h23; rom[12'h2AA] = 8'h70;
        rom[12'h2AB] = 8'hB1; rom[12'h2AC] = 8'h23;
        rom[12'h2AD] = 8'h90; rom[12'h2AE] = 8'hA0;
        rom[12'h2AF] = 8'h4F; rom[12'h2B0] = 8'hFF;
        rom[12'hFFF] = 8'h40;
        in_port = 4'h6;
        run_prog(30);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4096; i++) begin
                rom[i] = 8'($urandom);
                ram[i] = 4'($urandom);
            end
            in_port = 4'($urandom);
            run_prog(150);
        end

        fill_nop();
        rom[12'h000] = 8'hC1;
        rom[12'h001] = 8'h23;
        ram[12'h123] = 4'h5;
        run = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("st_exec", 64'({data_we, data_addr, data_out}),
            64'({1'b1, 12'h123, 4'h0}));
        reset = 1'b0;
        #1;
        chk("async_rst", 64'({pc, data_we, alu_s, alu_b}), 64'h0);
        @(posedge clk);
        #1;
        chk("no_write", 64'(ram[12'h123]), 64'h5);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
